// File: rtl/mem_init_arbiter.sv
// Memory port arbiter: a download path, an address-range eraser and the CPU share one
// registered memory port, with download > erase > CPU priority evaluated every cycle.
module mem_init_arbiter #(
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       ERASE_START    = 0,
  parameter int unsigned       ERASE_END      = (2**ADDR_W) - 1,
  parameter logic [DATA_W-1:0] FILL           = '0,
  parameter int unsigned       ERASE_ON_RESET = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              erase_req,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic              cpu_hold,
  output logic              eraser_busy,
  output logic              erase_done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ERASE    = 2'd1;
  localparam logic [1:0] ST_DOWNLOAD = 2'd2;

  localparam logic [ADDR_W-1:0] START_C    = ADDR_W'(ERASE_START);
  localparam logic [ADDR_W-1:0] END_C      = ADDR_W'(ERASE_END);
  localparam logic [ADDR_W-1:0] ONE_C      = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic              BUSY_RST_C = (ERASE_ON_RESET != 0) ? 1'b1 : 1'b0;

  logic [1:0]        state_s;
  logic [ADDR_W-1:0] eff_cnt_s;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              fin_q, fin_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;

  // Owner selection, erase bookkeeping and next memory-port values.
  always_comb begin
    if (dl_active) begin
      state_s = ST_DOWNLOAD;
    end else if (busy_q) begin
      state_s = ST_ERASE;
    end else begin
      state_s = ST_IDLE;
    end

    // A restart request takes effect on the write issued in the same cycle.
    eff_cnt_s  = erase_req ? START_C : cnt_q;

    busy_d     = busy_q;
    fin_d      = fin_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;

    // fin_q marks the cycle after the last address was issued: the erase completes then,
    // whoever owns the port.
    if (erase_req) begin
      busy_d = 1'b1;
      fin_d  = 1'b0;
      cnt_d  = START_C;
    end else if (fin_q) begin
      busy_d = 1'b0;
      fin_d  = 1'b0;
      done_d = 1'b1;
    end else begin
      busy_d = busy_q;
    end

    case (state_s)
      ST_DOWNLOAD: begin
        mem_addr_d = dl_addr;
        mem_din_d  = dl_data;
        mem_wr_d   = dl_wr;
        mem_rd_d   = 1'b0;
      end
      ST_ERASE: begin
        if (erase_req || !fin_q) begin
          mem_addr_d = eff_cnt_s;
          mem_din_d  = FILL;
          mem_wr_d   = 1'b1;
          // End of range is found by comparison so a full-width range never wraps.
          if (eff_cnt_s == END_C) begin
            fin_d = 1'b1;
            cnt_d = eff_cnt_s;
          end else begin
            fin_d = 1'b0;
            cnt_d = eff_cnt_s + ONE_C;
          end
        end else begin
          mem_wr_d = 1'b0;
        end
      end
      default: begin
        mem_addr_d = cpu_addr;
        mem_din_d  = cpu_dout;
        mem_wr_d   = cpu_wr;
        mem_rd_d   = cpu_rd;
      end
    endcase
  end

  // State and registered memory port.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q      <= START_C;
      busy_q     <= BUSY_RST_C;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  // The CPU is stalled whenever download holds the port or an erase is outstanding.
  assign cpu_hold    = busy_q | (dl_active & ~reset);
  assign eraser_busy = busy_q;
  assign erase_done  = done_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;

endmodule

// File: doc/mem_init_arbiter.md
MEM_INIT_ARBITER -- requirements
Module: mem_init_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: memory address width.
REQ-002 Parameter DATA_W, default 8: memory data width.
REQ-003 Parameter ERASE_START, default 0: first address written by the eraser.
REQ-004 Parameter ERASE_END, default 2**ADDR_W-1: last address written by the eraser (inclusive); ERASE_END >= ERASE_START.
REQ-005 Parameter FILL, default 0: DATA_W-bit value written by the eraser.
REQ-006 Parameter ERASE_ON_RESET, default 1: when 1, an erase starts automatically on reset release.
REQ-007 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 erase_req  in  1  single-cycle request to start or restart an erase.
REQ-010 dl_active  in  1  download in progress; the download path owns memory while high.
REQ-011 dl_wr  in  1  download write strobe; qualified by dl_active.
REQ-012 dl_addr  in  ADDR_W  download address.
REQ-013 dl_data  in  DATA_W  download write data.
REQ-014 cpu_addr  in  ADDR_W  CPU address.
REQ-015 cpu_dout  in  DATA_W  CPU write data.
REQ-016 cpu_rd  in  1  CPU read strobe.
REQ-017 cpu_wr  in  1  CPU write strobe.
REQ-018 mem_addr  out  ADDR_W  registered memory address.
REQ-019 mem_din  out  DATA_W  registered memory write data.
REQ-020 mem_wr  out  1  registered memory write enable.
REQ-021 mem_rd  out  1  registered memory read enable.
REQ-022 cpu_hold  out  1  CPU must stall; high whenever the CPU is not the memory owner.
REQ-023 eraser_busy  out  1  high while an erase is pending or in progress, including while paused.
REQ-024 erase_done  out  1  single-cycle pulse when an erase completes.

Function
REQ-025 The block SHALL implement the states IDLE (CPU owns memory), ERASE and DOWNLOAD.
REQ-026 Ownership priority SHALL be DOWNLOAD > ERASE > CPU, evaluated every cycle.
REQ-027 All mem_* outputs SHALL be registered, with exactly 1 cycle of latency from the owner's inputs.
REQ-028 In IDLE, mem_addr, mem_din, mem_wr and mem_rd SHALL follow cpu_addr, cpu_dout, cpu_wr and cpu_rd, and cpu_hold SHALL be 0.
REQ-029 While dl_active=1, the state SHALL be DOWNLOAD, with mem_addr<=dl_addr, mem_din<=dl_data, mem_wr<=dl_wr and mem_rd<=0.
REQ-030 dl_wr with dl_active=0 SHALL be ignored.
REQ-031 The ERASE state SHALL write FILL to one address per cycle, ascending from ERASE_START through ERASE_END, with mem_wr=1 each cycle.
REQ-032 The cycle after ERASE_END is written, the block SHALL pulse erase_done for 1 cycle, drop eraser_busy and move to IDLE (or DOWNLOAD if dl_active=1).
REQ-033 If dl_active rises during ERASE, the erase counter SHALL hold its value and DOWNLOAD SHALL take over; when dl_active falls, the erase SHALL resume at the held address, with no address skipped or repeated.
REQ-034 If erase_req arrives during ERASE, or during a paused erase, the counter SHALL restart at ERASE_START.
REQ-035 If erase_req arrives during DOWNLOAD, it SHALL be latched (eraser_busy=1), and the erase SHALL start when dl_active falls.
REQ-036 CPU cpu_wr and cpu_rd asserted while cpu_hold=1 SHALL NOT reach memory; they SHALL be neither buffered nor replayed.
REQ-037 cpu_hold SHALL be 1 in ERASE and DOWNLOAD, and whenever eraser_busy=1.
REQ-038 The erase counter SHALL be ADDR_W bits wide, with no wrap-around beyond ERASE_END; when ERASE_END=2**ADDR_W-1, termination SHALL be detected by comparison, not by overflow.
REQ-039 When ERASE_START=ERASE_END, the erase SHALL consist of exactly one write.

Reset
REQ-040 While reset=1, mem_addr=0, mem_din=0, mem_wr=0, mem_rd=0 and erase_done=0.
REQ-041 While reset=1, if ERASE_ON_RESET=1, eraser_busy=1 and cpu_hold=1, and the erase counter SHALL equal ERASE_START.
REQ-042 While reset=1, if ERASE_ON_RESET=0, eraser_busy=0 and cpu_hold=0.
REQ-043 Reset asserted mid-erase or mid-download SHALL abort the operation immediately and asynchronously.
REQ-044 After reset deasserts, the first memory write SHALL occur no earlier than the first rising clk_sys edge following reset deassertion.

Verification
REQ-045 Auto-erase: set ERASE_ON_RESET=1, ERASE_START=0x0000, ERASE_END=0x000F, FILL=0xA5, then release reset -> 16 consecutive writes of 0xA5 to addresses 0x0..0xF; erase_done pulses once; cpu_hold falls the following cycle.
REQ-046 Download pause: set dl_active=1 after the erase writes address 0x0005, hold it for 3 cycles with dl_wr writing 0x42 to 0x1234 -> 0x42 is written to 0x1234; the erase resumes at 0x0006; all 16 addresses are written exactly once.
REQ-047 CPU pass-through: in IDLE, set cpu_wr=1, cpu_addr=0x0200, cpu_dout=0x7E -> mem_wr=1, mem_addr=0x0200, mem_din=0x7E exactly one cycle later.
REQ-048 Restart: pulse erase_req while the erase is at address 0x0008 -> the next write goes to ERASE_START, and erase_done pulses only after the full range has been written.
REQ-049 Boundary: set ADDR_W=4, ERASE_END=0xF -> 16 writes, the counter does not wrap, erase_done pulses; a second run with ERASE_START=ERASE_END=0x3 produces a single write.
REQ-050 Reset abort: assert reset mid-erase -> mem_wr=0 within the same cycle, asynchronously; after release with ERASE_ON_RESET=1 the erase restarts at ERASE_START.
